// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: valid/ready sequencer for a PIPE_DEPTH-stage chain of
// datapath registers that live outside this block. Each stage advances when
// it is empty or its successor advances, so bubbles collapse and only blocked
// valid stages hold their contents.
//
// Ports
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   in_valid       upstream offers an item
//   in_ready       stage 0 can take an item (combinational)
//   out_valid      last stage holds an item (combinational, masked by halt)
//   out_ready      downstream takes the item
//   halt           freeze every stage and the stall counter
//   flush          synchronous clear of all stage valids
//   perf_clr       synchronous clear of stall_cnt
//   en             per-stage load enable for the external registers (combinational)
//   stage_valid    registered valid bit per stage
//   occupancy      registered count of valid stages
//   stall_cnt      saturating count of cycles with out_valid & !out_ready
module pipe_stall_ctrl #(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            halt,
  input  logic                            flush,
  input  logic                            perf_clr,
  output logic [PIPE_DEPTH-1:0]           en,
  output logic [PIPE_DEPTH-1:0]           stage_valid,
  output logic [$clog2(PIPE_DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]                stall_cnt
);

  localparam int unsigned D     = PIPE_DEPTH;
  localparam int unsigned OCC_W = $clog2(PIPE_DEPTH + 1);

  logic [D-1:0]     en_c;
  logic [D-1:0]     valid_nxt;
  logic [D-1:0]     shift_in;
  logic [OCC_W-1:0] occ_nxt;
  logic             stall_evt;

  // Enable chain walked from the output back to stage 0; an empty stage
  // always loads, a full one loads only if its successor moves on.
  always_comb begin
    logic chain;
    en_c  = '0;
    chain = out_ready;
    for (int i = int'(D) - 1; i >= 0; i--) begin
      en_c[i] = !halt && !flush && (!stage_valid[i] || chain);
      chain   = en_c[i];
    end
  end

  assign en        = en_c;
  assign in_ready  = en_c[0];
  assign out_valid = stage_valid[D-1] && !halt;
  assign stall_evt = out_valid && !out_ready;

  // Each stage's load value is its predecessor's valid; stage 0 takes in_valid.
  assign shift_in = D'({stage_valid, in_valid});

  // Next valid vector and its population count for the occupancy register.
  always_comb begin
    valid_nxt = flush ? '0 : ((en_c & shift_in) | (~en_c & stage_valid));
    occ_nxt   = '0;
    for (int i = 0; i < int'(D); i++) begin
      occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
    end
  end

  // Stage valids and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      occupancy   <= '0;
    end else begin
      stage_valid <= valid_nxt;
      occupancy   <= occ_nxt;
    end
  end

  // Saturating stall counter; clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with PIPE_DEPTH=3 and CNT_W=4.
module tb_pipe_stall_ctrl;

  localparam int unsigned D     = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OCC_W = $clog2(D + 1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             halt;
  logic             flush;
  logic             perf_clr;
  logic [D-1:0]     en;
  logic [D-1:0]     stage_valid;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl #(.PIPE_DEPTH(D), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halt       (halt),
    .flush      (flush),
    .perf_clr   (perf_clr),
    .en         (en),
    .stage_valid(stage_valid),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered state: stage_valid, occupancy, stall_cnt.
  task automatic chk_st(input string tag, input logic [2:0] sv, input int occ, input int sc);
    chk({tag, ".stage_valid"}, 32'(stage_valid), 32'(sv));
    chk({tag, ".occupancy"},   32'(occupancy),   32'(occ));
    chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(sc));
  endtask

  // Combinational outputs, sampled 1 ns after the inputs last changed.
  task automatic chk_cb(input string tag, input logic [2:0] e, input logic ir, input logic ov);
    #1;
    chk({tag, ".en"},        32'(en),        32'(e));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    halt = 1'b0; flush = 1'b0; perf_clr = 1'b0;
    chk_cb("rst", 3'b111, 1'b1, 1'b0);
    chk_st("rst", 3'b000, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // Streaming: first out_valid three edges after the first accept.
    in_valid = 1'b1; out_ready = 1'b1;
    chk_cb("s0", 3'b111, 1'b1, 1'b0);
    tick(); chk_st("s1", 3'b001, 1, 0);
    tick(); chk_st("s2", 3'b011, 2, 0);
    chk_cb("s2", 3'b111, 1'b1, 1'b0);
    tick(); chk_st("s3", 3'b111, 3, 0);
    chk_cb("s3", 3'b111, 1'b1, 1'b1);
    tick(); tick(); chk_st("s5", 3'b111, 3, 0);

    // Full pipe blocked for five cycles, then drained.
    out_ready = 1'b0;
    chk_cb("blk", 3'b000, 1'b0, 1'b1);
    repeat (5) tick();
    chk_st("blk5", 3'b111, 3, 5);
    out_ready = 1'b1; in_valid = 1'b0;
    chk_cb("dr0", 3'b111, 1'b1, 1'b1);
    tick(); chk_st("dr1", 3'b110, 2, 5);
    tick(); chk_st("dr2", 3'b100, 1, 5);
    chk_cb("dr2", 3'b111, 1'b1, 1'b1);
    tick(); chk_st("dr3", 3'b000, 0, 5);
    chk_cb("dr3", 3'b111, 1'b1, 1'b0);

    // Hole collapse: build 101 with the output blocked.
    out_ready = 1'b0;
    in_valid = 1'b1; tick(); chk_st("h1", 3'b001, 1, 5);
    in_valid = 1'b0; tick(); chk_st("h2", 3'b010, 1, 5);
    in_valid = 1'b1; tick(); chk_st("h3", 3'b101, 2, 5);
    chk_cb("h3", 3'b011, 1'b1, 1'b1);
    tick(); chk_st("h4", 3'b111, 3, 6);
    chk_cb("h4", 3'b000, 1'b0, 1'b1);

    // Flush of a full pipe with input offered; counter survives.
    flush = 1'b1;
    chk_cb("fl", 3'b000, 1'b0, 1'b1);
    tick(); flush = 1'b0;
    chk_st("fl1", 3'b000, 0, 7);

    // Halt a full pipe for four cycles, then resume draining.
    out_ready = 1'b1; in_valid = 1'b1;
    tick(); tick(); tick(); chk_st("hp", 3'b111, 3, 7);
    halt = 1'b1; out_ready = 1'b0;
    chk_cb("hlt", 3'b000, 1'b0, 1'b0);
    repeat (4) tick();
    chk_st("hlt4", 3'b111, 3, 7);
    halt = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    chk_cb("rel", 3'b111, 1'b1, 1'b1);
    tick(); chk_st("rel1", 3'b110, 2, 7);
    tick(); chk_st("rel2", 3'b100, 1, 7);
    tick(); chk_st("rel3", 3'b000, 0, 7);

    // Saturation, clear priority, restart.
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick(); chk_st("sat0", 3'b111, 3, 7);
    repeat (20) tick();
    chk_st("sat", 3'b111, 3, 15);
    perf_clr = 1'b1;
    tick(); perf_clr = 1'b0;
    chk_st("clr", 3'b111, 3, 0);
    tick(); chk_st("clr1", 3'b111, 3, 1);

    // Asynchronous reset between edges.
    reset = 1'b1;
    chk_cb("arst", 3'b111, 1'b1, 1'b0);
    chk_st("arst", 3'b000, 0, 0);
    tick();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
